// File: rtl/w_window_sequencer.sv
// w_window_sequencer: arms on s, splits w into back-to-back WIN_LEN windows, reports exactly-TARGET-ones per window over valid/ready
module w_window_sequencer #(
    parameter int WIN_LEN     = 3,
    parameter int TARGET      = 2,
    parameter int MAX_WINDOWS = 0,
    parameter int WCNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s,
    input  logic              abort,
    input  logic              w,
    input  logic              z_ready,
    output logic              z_valid,
    output logic              z,
    output logic              busy,
    output logic [WCNT_W-1:0] win_count,
    output logic              overrun
);
    localparam int CW = $clog2(WIN_LEN + 1);
    localparam int SW = $clog2(WIN_LEN);
    localparam logic IDLE = 1'b0;
    localparam logic SAMPLE = 1'b1;
    logic          state;
    logic [SW-1:0] scnt;
    logic [CW-1:0] ones, ones_nxt;
    logic          last, arm, final_win;
    always_comb begin
        ones_nxt  = ones + CW'(w);
        last      = state == SAMPLE && scnt == SW'(WIN_LEN - 1);
        arm       = state == IDLE && s && !abort;
        final_win = MAX_WINDOWS != 0 && 32'(win_count) + 32'd1 == 32'(MAX_WINDOWS);
    end
    assign busy = state == SAMPLE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            scnt      <= '0;
            ones      <= '0;
            z_valid   <= 1'b0;
            z         <= 1'b0;
            win_count <= '0;
            overrun   <= 1'b0;
        end else begin
            if (z_valid && z_ready) z_valid <= 1'b0;
            if (arm) begin
                state     <= SAMPLE;
                scnt      <= '0;
                ones      <= '0;
                win_count <= '0;
                overrun   <= 1'b0;
            end else if (state == SAMPLE && abort) begin
                state <= IDLE;
                scnt  <= '0;
                ones  <= '0;
            end else if (last) begin
                // a load onto an unconsumed result loses that result
                scnt    <= '0;
                ones    <= '0;
                z       <= ones_nxt == CW'(TARGET);
                z_valid <= 1'b1;
                overrun <= overrun | (z_valid & ~z_ready);
                if (~&win_count) win_count <= win_count + WCNT_W'(1);
                if (final_win) state <= IDLE;
            end else if (state == SAMPLE) begin
                scnt <= scnt + SW'(1);
                ones <= ones_nxt;
            end
        end
    end
endmodule

// File: tb/tb_w_window_sequencer.sv
// tb_w_window_sequencer: directed tests for the default window checker and a bounded-window variant
module tb_w_window_sequencer;
    logic clk = 1'b0, reset = 1'b0, s = 1'b0, abort = 1'b0, w = 1'b0, z_ready = 1'b0;
    logic a_valid, a_z, a_busy, a_ovr;
    logic [7:0] a_wc;
    logic b_valid, b_z, b_busy, b_ovr;
    logic [7:0] b_wc;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    w_window_sequencer u0 (
        .clk(clk), .reset(reset), .s(s), .abort(abort), .w(w), .z_ready(z_ready),
        .z_valid(a_valid), .z(a_z), .busy(a_busy), .win_count(a_wc), .overrun(a_ovr)
    );

    w_window_sequencer #(.WIN_LEN(4), .TARGET(0), .MAX_WINDOWS(2), .WCNT_W(8)) u1 (
        .clk(clk), .reset(reset), .s(s), .abort(abort), .w(w), .z_ready(z_ready),
        .z_valid(b_valid), .z(b_z), .busy(b_busy), .win_count(b_wc), .overrun(b_ovr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s = 1'($urandom); w = 1'($urandom); z_ready = 1'($urandom);
            tick();
        end
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", a_valid); end
        checks++; if (a_z !== 1'b0) begin errors++; $display("FAIL reset_z got %b exp 0", a_z); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", a_busy); end
        checks++; if (a_wc !== 8'd0) begin errors++; $display("FAIL reset_wc got %0d exp 0", a_wc); end
        checks++; if (a_ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", a_ovr); end
        checks++; if ({b_valid, b_busy, b_ovr} !== 3'b000) begin errors++; $display("FAIL reset_b got %b exp 000", {b_valid, b_busy, b_ovr}); end
        reset = 1'b0; s = 1'b0; w = 1'b0; z_ready = 1'b0;
    endtask

    task automatic test_match();
        z_ready = 1'b1; s = 1'b1; tick(); s = 1'b0;
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL arm_busy got %b exp 1", a_busy); end
        w = 1'b1; tick(); tick(); w = 1'b0; tick();
        checks++; if ({a_valid, a_z} !== 2'b11) begin errors++; $display("FAIL match_w110 got %b exp 11", {a_valid, a_z}); end
        checks++; if (a_wc !== 8'd1) begin errors++; $display("FAIL match_wc1 got %0d exp 1", a_wc); end
        w = 1'b1; tick();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL match_xfer got %b exp 0", a_valid); end
        tick(); tick();
        checks++; if ({a_valid, a_z} !== 2'b10) begin errors++; $display("FAIL match_w111 got %b exp 10", {a_valid, a_z}); end
        checks++; if (a_wc !== 8'd2) begin errors++; $display("FAIL match_wc2 got %0d exp 2", a_wc); end
    endtask

    task automatic test_overrun();
        z_ready = 1'b0;
        w = 1'b1; tick(); w = 1'b0; tick(); w = 1'b1; tick();
        w = 1'b0; tick(); tick(); tick();
        checks++; if ({a_valid, a_z, a_ovr} !== 3'b101) begin errors++; $display("FAIL ovr_hold got %b exp 101", {a_valid, a_z, a_ovr}); end
        checks++; if (a_wc !== 8'd4) begin errors++; $display("FAIL ovr_wc got %0d exp 4", a_wc); end
        z_ready = 1'b1; tick();
        checks++; if ({a_valid, a_ovr} !== 2'b01) begin errors++; $display("FAIL ovr_drain got %b exp 01", {a_valid, a_ovr}); end
        abort = 1'b1; tick(); abort = 1'b0;
        s = 1'b1; tick(); s = 1'b0;
        checks++; if ({a_busy, a_ovr, a_wc} !== {2'b10, 8'd0}) begin errors++; $display("FAIL ovr_rearm got busy=%b ovr=%b wc=%0d exp busy=1 ovr=0 wc=0", a_busy, a_ovr, a_wc); end
    endtask

    task automatic test_abort();
        w = 1'b1; tick(); tick(); w = 1'b0; tick();
        w = 1'b1; tick();
        abort = 1'b1; tick(); abort = 1'b0;
        checks++; if ({a_busy, a_valid, a_wc} !== {2'b00, 8'd1}) begin errors++; $display("FAIL abort_mid got busy=%b valid=%b wc=%0d exp 0 0 1", a_busy, a_valid, a_wc); end
        tick();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL abort_noresult got %b exp 0", a_valid); end
        s = 1'b1; abort = 1'b1; tick();
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL abort_prio got %b exp 0", a_busy); end
        abort = 1'b0; tick(); s = 1'b0;
        checks++; if ({a_busy, a_wc} !== {1'b1, 8'd0}) begin errors++; $display("FAIL abort_rearm got busy=%b wc=%0d exp 1 0", a_busy, a_wc); end
        w = 1'b1; tick(); tick(); tick();
        tick(); tick();
        abort = 1'b1; tick(); abort = 1'b0;
        checks++; if ({a_busy, a_valid, a_wc} !== {2'b00, 8'd1}) begin errors++; $display("FAIL abort_edge got busy=%b valid=%b wc=%0d exp 0 0 1", a_busy, a_valid, a_wc); end
    endtask

    task automatic test_back_to_back();
        s = 1'b1; tick(); s = 1'b0;
        z_ready = 1'b0;
        w = 1'b1; tick(); tick(); w = 1'b0; tick();
        checks++; if ({a_valid, a_z} !== 2'b11) begin errors++; $display("FAIL b2b_first got %b exp 11", {a_valid, a_z}); end
        w = 1'b1; tick(); w = 1'b0; tick();
        z_ready = 1'b1; tick();
        checks++; if ({a_valid, a_z, a_ovr} !== 3'b100) begin errors++; $display("FAIL b2b_load got %b exp 100", {a_valid, a_z, a_ovr}); end
        checks++; if (a_wc !== 8'd2) begin errors++; $display("FAIL b2b_wc got %0d exp 2", a_wc); end
        tick();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", a_valid); end
    endtask

    task automatic test_max_windows();
        reset = 1'b1; tick(); reset = 1'b0;
        z_ready = 1'b1; w = 1'b0; s = 1'b1; tick(); s = 1'b0;
        tick(); tick(); tick(); tick();
        checks++; if ({b_valid, b_z, b_busy, b_wc} !== {3'b111, 8'd1}) begin errors++; $display("FAIL max_first got v=%b z=%b busy=%b wc=%0d exp 1 1 1 1", b_valid, b_z, b_busy, b_wc); end
        s = 1'b1; tick(); tick(); tick(); tick();
        checks++; if ({b_valid, b_z, b_busy, b_wc} !== {3'b110, 8'd2}) begin errors++; $display("FAIL max_second got v=%b z=%b busy=%b wc=%0d exp 1 1 0 2", b_valid, b_z, b_busy, b_wc); end
        s = 1'b0; tick();
        checks++; if ({b_valid, b_busy} !== 2'b00) begin errors++; $display("FAIL max_idle got %b exp 00", {b_valid, b_busy}); end
        s = 1'b1; tick(); s = 1'b0;
        checks++; if ({b_busy, b_wc} !== {1'b1, 8'd0}) begin errors++; $display("FAIL max_rearm got busy=%b wc=%0d exp 1 0", b_busy, b_wc); end
    endtask

    initial begin
        test_reset();
        test_match();
        test_overrun();
        test_abort();
        test_back_to_back();
        test_max_windows();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
